ps2_host_tx: RTL and testbench
==============================

// Module: ps2_host_tx
// PURPOSE
//  PS/2 host-to-device transmitter: sends one command byte (LED set 8'hED, reset 8'hFF, ...) to the keyboard.
//  Runs the full request-to-send sequence, shifts data/parity/stop on device-generated clocks, checks the device ACK.
//  Shares the open-drain ps2 clk/dat pins with the existing scancode receiver, which holds off while tx_busy=1.
// PARAMETERS
//  CLK_FREQ        28000000  system clock frequency in Hz; all timers are derived from it
//  INHIBIT_US      100       time ps2 clock is held low before the start bit
//  START_TMO_US    15000     max wait from clock release to first device falling edge
//  BIT_TMO_US      2000      max gap between consecutive device falling edges
//  FILTER_LEN      8         clk cycles ps2_clk_in must be stable before an edge is accepted
// PORTS
//  clk          in   1  system clock
//  rst          in   1  asynchronous reset, active-high
//  ps2_clk_in   in   1  ps2 clock pin level (asynchronous; 2-FF synchronised internally)
//  ps2_dat_in   in   1  ps2 data pin level (asynchronous; 2-FF synchronised internally)
//  ps2_clk_out  out  1  0 = pull clock low, 1 = release
//  ps2_dat_out  out  1  0 = pull data low, 1 = release
//  tx_data      in   8  byte to send, sampled when tx_valid & tx_ready
//  tx_valid     in   1  request to send tx_data
//  tx_ready     out  1  1 in IDLE only
//  tx_busy      out  1  1 in every state except IDLE
//  tx_done      out  1  1-cycle pulse: byte sent and ACK received
//  tx_error     out  1  1-cycle pulse: NACK or timeout; lines released
// BEHAVIOUR
//  Reset: ps2_clk_out=1, ps2_dat_out=1, tx_ready=1, tx_busy=0, tx_done=0, tx_error=0, state IDLE, counters 0.
//  Edge detect: filtered ps2 clock; "fall" = stable 1 -> stable 0 for FILTER_LEN cycles; 1 cycle after filter.
//  Shift reg = {1'b1 stop, ~^tx_data odd parity, tx_data}; LSB first after start bit.
//  FSM:
//   IDLE    : tx_valid -> latch data, clk_out=0, timer=0 -> INHIBIT (tx_ready drops next cycle)
//   INHIBIT : hold clk_out=0 for INHIBIT_US; then dat_out=0 (start) for 1 more cycle -> RELEASE
//   RELEASE : clk_out=1, dat_out=0; wait fall; START_TMO_US expiry -> ERROR
//   SHIFT   : on falls 1..9 drive bit0..bit7, parity onto dat_out; on fall 10 dat_out=1 (stop); count 0..10
//             gap between falls > BIT_TMO_US -> ERROR
//   ACK     : on fall 11 sample synced ps2_dat_in: 0 -> WAIT_IDLE, 1 -> ERROR (NACK); timeout -> ERROR
//   WAIT_IDLE: wait clk and dat both high (synced) -> tx_done pulse, IDLE; timeout BIT_TMO_US -> ERROR
//   ERROR   : clk_out=1, dat_out=1, tx_error pulse 1 cycle -> IDLE
//  Timers: one counter, width $clog2(CLK_FREQ/1e6*START_TMO_US)+1, cleared on every state change and every fall.
//  tx_valid while busy: ignored (not queued). tx_done and tx_error never assert together.
//  Device clock activity while IDLE: ignored; outputs stay released.
//  Async rst mid-transfer: lines released immediately (combinational from reset flops), no pulse emitted.
//  Output latency: clk_out falls 1 cycle after accepted tx_valid; total frame ~ INHIBIT + 11 device clocks.
// CONFIGURATION
//  PS2_TX_RETRY_EN defined: on NACK or timeout, first failure silently re-enters INHIBIT with the latched byte;
//    tx_error pulses only if the retry also fails; tx_busy stays 1 throughout the retry.
//  PS2_TX_RETRY_EN undefined: any failure goes straight to ERROR (single attempt); retry counter not built.
// TESTING
//  tx_data=8'hED, device model ACKs -> clk_out low 100us, data bits 1,0,1,1,0,1,1,1, parity 1, stop 1, tx_done once.
//  tx_data=8'hF4 -> bits 0,0,1,0,1,1,1,1, parity 0; tx_done 1 cycle after lines idle-high.
//  Device leaves data high on 11th clock -> tx_error pulse (retry off) / second full frame then tx_error (retry on).
//  No device clock after release -> tx_error at 15ms +/- 1 cycle; clk_out=dat_out=1 afterwards.
//  Device stops after bit 4 -> tx_error 2ms after last fall; tx_valid during frame has no effect.
//  rst=1 during SHIFT -> clk_out=dat_out=1 same cycle, no tx_done/tx_error; new tx_valid after rst starts fresh frame.

Source files
------------

// File: rtl/ps2_host_tx.sv
`default_nettype none
// ============================================================================
// Module   : ps2_host_tx
// Purpose  : PS/2 host-to-device command transmitter. It pulls the clock low to
//            request a send, shifts the frame out on device clocks, and then
//            checks the device ACK.
// Option   : PS2_TX_RETRY_EN - retry once on NACK/timeout before reporting error
// Revision : 1.0
// ============================================================================
module ps2_host_tx #(
    parameter int CLK_FREQ     = 28000000,
    parameter int INHIBIT_US   = 100,
    parameter int START_TMO_US = 15000,
    parameter int BIT_TMO_US   = 2000,
    parameter int FILTER_LEN   = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk_in,
    input  logic       ps2_dat_in,
    output logic       ps2_clk_out,
    output logic       ps2_dat_out,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_error
);

    localparam int CYC_PER_US = CLK_FREQ / 1000000;
    localparam int TMR_W      = $clog2(CYC_PER_US * START_TMO_US) + 1;
    localparam int FCNT_W     = $clog2(FILTER_LEN + 1);

    localparam logic [TMR_W-1:0]  INH_LIM   = TMR_W'(CYC_PER_US * INHIBIT_US);
    localparam logic [TMR_W-1:0]  START_LIM = TMR_W'(CYC_PER_US * START_TMO_US - 1);
    localparam logic [TMR_W-1:0]  BIT_LIM   = TMR_W'(CYC_PER_US * BIT_TMO_US - 1);
    localparam logic [FCNT_W-1:0] FLT_LIM   = FCNT_W'(FILTER_LEN - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_INHIBIT   = 3'd1,
        S_RELEASE   = 3'd2,
        S_SHIFT     = 3'd3,
        S_ACK       = 3'd4,
        S_WAIT_IDLE = 3'd5,
        S_ERROR     = 3'd6
    } state_t;

    logic [1:0]        clk_sync_q;
    logic [1:0]        dat_sync_q;
    logic              filt_q;
    logic [FCNT_W-1:0] fcnt_q;
    logic              fall_q;

    state_t            state_q, state_d;
    logic [TMR_W-1:0]  timer_q, timer_d;
    logic [3:0]        bcnt_q, bcnt_d;
    logic [7:0]        data_q, data_d;
    logic              done_q, done_d;
    logic              w_fail;

    logic              w_clk_s;
    logic              w_dat_s;
    logic [9:0]        w_frame;
    logic [3:0]        w_bit_idx;

    assign w_clk_s   = clk_sync_q[1];
    assign w_dat_s   = dat_sync_q[1];
    assign w_frame   = {1'b1, ~^data_q, data_q};
    assign w_bit_idx = bcnt_q - 4'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_sync_q <= 2'b11;
            dat_sync_q <= 2'b11;
        end else begin
            clk_sync_q <= {clk_sync_q[0], ps2_clk_in};
            dat_sync_q <= {dat_sync_q[0], ps2_dat_in};
        end
    end

    // A level change is accepted only after FILTER_LEN consecutive differing samples.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            filt_q <= 1'b1;
            fcnt_q <= '0;
            fall_q <= 1'b0;
        end else begin
            fall_q <= 1'b0;
            if (w_clk_s == filt_q) begin
                fcnt_q <= '0;
            end else if (fcnt_q == FLT_LIM) begin
                filt_q <= w_clk_s;
                fcnt_q <= '0;
                fall_q <= ~w_clk_s;
            end else begin
                fcnt_q <= fcnt_q + FCNT_W'(1);
            end
        end
    end

`ifdef PS2_TX_RETRY_EN
    logic retry_q, retry_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            retry_q <= 1'b0;
        end else begin
            retry_q <= retry_d;
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            timer_q <= '0;
            bcnt_q  <= '0;
            data_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            bcnt_q  <= bcnt_d;
            data_q  <= data_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        timer_d = timer_q + TMR_W'(1);
        bcnt_d  = bcnt_q;
        data_d  = data_q;
        done_d  = 1'b0;
        w_fail  = 1'b0;
`ifdef PS2_TX_RETRY_EN
        retry_d = retry_q;
`endif
        case (state_q)
            S_IDLE: begin
                timer_d = '0;
                bcnt_d  = '0;
`ifdef PS2_TX_RETRY_EN
                retry_d = 1'b0;
`endif
                if (tx_valid) begin
                    data_d  = tx_data;
                    state_d = S_INHIBIT;
                end
            end
            S_INHIBIT: begin
                if (timer_q == INH_LIM) begin
                    state_d = S_RELEASE;
                end
            end
            S_RELEASE: begin
                if (fall_q) begin
                    bcnt_d  = 4'd1;
                    state_d = S_SHIFT;
                end else if (timer_q == START_LIM) begin
                    w_fail = 1'b1;
                end
            end
            S_SHIFT: begin
                if (fall_q) begin
                    bcnt_d = bcnt_q + 4'd1;
                    if (bcnt_q == 4'd9) begin
                        state_d = S_ACK;
                    end
                end else if (timer_q == BIT_LIM) begin
                    w_fail = 1'b1;
                end
            end
            S_ACK: begin
                if (fall_q) begin
                    if (w_dat_s) begin
                        w_fail = 1'b1;
                    end else begin
                        state_d = S_WAIT_IDLE;
                    end
                end else if (timer_q == BIT_LIM) begin
                    w_fail = 1'b1;
                end
            end
            S_WAIT_IDLE: begin
                if (w_clk_s && w_dat_s) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else if (timer_q == BIT_LIM) begin
                    w_fail = 1'b1;
                end
            end
            S_ERROR: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (w_fail) begin
`ifdef PS2_TX_RETRY_EN
            if (!retry_q) begin
                retry_d = 1'b1;
                state_d = S_INHIBIT;
            end else begin
                state_d = S_ERROR;
            end
`else
            state_d = S_ERROR;
`endif
            bcnt_d = '0;
        end

        // Our own inhibit pulls the pin low, so falls seen in INHIBIT must not restart the hold time.
        if ((state_d != state_q) || (fall_q && (state_q != S_INHIBIT))) begin
            timer_d = '0;
        end
    end

    always_comb begin
        ps2_clk_out = 1'b1;
        ps2_dat_out = 1'b1;
        case (state_q)
            S_INHIBIT: begin
                ps2_clk_out = 1'b0;
                ps2_dat_out = (timer_q != INH_LIM);
            end
            S_RELEASE: begin
                ps2_dat_out = 1'b0;
            end
            S_SHIFT: begin
                ps2_dat_out = w_frame[w_bit_idx];
            end
            default: begin
                ps2_dat_out = 1'b1;
            end
        endcase
    end

    assign tx_ready = (state_q == S_IDLE);
    assign tx_busy  = (state_q != S_IDLE);
    assign tx_done  = done_q;
    assign tx_error = (state_q == S_ERROR);

endmodule
`default_nettype wire

// File: tb/tb_ps2_host_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_ps2_host_tx
// Purpose  : Directed self-checking bench for ps2_host_tx with a PS/2 device model.
// Revision : 1.0
// ============================================================================
module tb_ps2_host_tx;

    localparam int HALF      = 40;
    localparam int INH_TOTAL = 101;
    localparam int START_CYC = 15000;
    localparam int BIT_CYC   = 2000;
    localparam int FLEN      = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       dev_clk = 1'b1;
    logic       dev_dat = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       ps2_clk_out, ps2_dat_out;
    logic       tx_ready, tx_busy, tx_done, tx_error;
    logic       ps2_clk_pin, ps2_dat_pin;

    int total = 0;
    int bad = 0;
    int done_cnt = 0;
    int err_cnt = 0;
    int both_cnt = 0;

    assign ps2_clk_pin = ps2_clk_out & dev_clk;
    assign ps2_dat_pin = ps2_dat_out & dev_dat;

    ps2_host_tx #(
        .CLK_FREQ    (1000000),
        .INHIBIT_US  (100),
        .START_TMO_US(15000),
        .BIT_TMO_US  (2000),
        .FILTER_LEN  (FLEN)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ps2_clk_in (ps2_clk_pin),
        .ps2_dat_in (ps2_dat_pin),
        .ps2_clk_out(ps2_clk_out),
        .ps2_dat_out(ps2_dat_out),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .tx_busy    (tx_busy),
        .tx_done    (tx_done),
        .tx_error   (tx_error)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (tx_done === 1'b1) done_cnt++;
        if (tx_error === 1'b1) err_cnt++;
        if (tx_done === 1'b1 && tx_error === 1'b1) both_cnt++;
    end

    task automatic start_tx(input logic [7:0] d);
        @(negedge clk);
        total++;
        if (tx_ready !== 1'b1) begin bad++; $display("FAIL ready_before_tx: got %b want 1", tx_ready); end
        tx_data  = d;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    // Waits for the host inhibit, measures it, returns at the first released cycle.
    task automatic dev_wait_release(output int low, output logic start_lvl);
        int guard;
        guard = 0;
        while (ps2_clk_out !== 1'b0 && guard < 20) begin @(negedge clk); guard++; end
        low = 0;
        while (ps2_clk_out === 1'b0 && low < 20000) begin low++; @(negedge clk); end
        start_lvl = ps2_dat_out;
    endtask

    // Device generates n clocks, sampling data on rising edges; clock 11 carries the ACK level.
    task automatic dev_clocks(input int n, input logic ack_lvl, output logic [9:0] bits);
        bits = '0;
        for (int i = 0; i < n; i++) begin
            if (i == 10) dev_dat = ack_lvl;
            dev_clk = 1'b0;
            repeat (HALF) @(negedge clk);
            dev_clk = 1'b1;
            if (i < 10) bits[i] = ps2_dat_pin;
            repeat (HALF) @(negedge clk);
            dev_dat = 1'b1;
        end
    endtask

    task automatic run_good_frame(input logic [7:0] d, input logic [9:0] exp_bits);
        int low, k, d0, e0;
        logic st;
        logic [9:0] bits;
        d0 = done_cnt; e0 = err_cnt;
        start_tx(d);
        total++;
        if ({tx_busy, tx_ready} !== 2'b10) begin bad++; $display("FAIL busy_ready_in_frame: got %b want 10", {tx_busy, tx_ready}); end
        dev_wait_release(low, st);
        total++;
        if (low != INH_TOTAL) begin bad++; $display("FAIL inhibit_len: got %0d want %0d", low, INH_TOTAL); end
        total++;
        if (st !== 1'b0) begin bad++; $display("FAIL start_bit: got %b want 0", st); end
        repeat (HALF) @(negedge clk);
        dev_clocks(11, 1'b0, bits);
        total++;
        if (bits !== exp_bits) begin bad++; $display("FAIL frame_bits %h: got %h want %h", d, bits, exp_bits); end
        k = 0;
        while (k < 20) begin @(negedge clk); k++; if (tx_done === 1'b1) break; end
        total++;
        if (k != 3) begin bad++; $display("FAIL done_latency: got %0d want 3", k); end
        repeat (5) @(negedge clk);
        total++;
        if (done_cnt - d0 != 1 || err_cnt - e0 != 0) begin
            bad++; $display("FAIL frame_pulses: done %0d err %0d want 1 0", done_cnt - d0, err_cnt - e0);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if ({ps2_clk_out, ps2_dat_out, tx_ready, tx_busy, tx_done, tx_error} !== 6'b111000) begin
            bad++; $display("FAIL reset_outputs: got %b want 111000",
                            {ps2_clk_out, ps2_dat_out, tx_ready, tx_busy, tx_done, tx_error});
        end
        rst = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if ({ps2_clk_out, ps2_dat_out, tx_ready, tx_busy} !== 4'b1110) begin
            bad++; $display("FAIL after_reset: got %b want 1110", {ps2_clk_out, ps2_dat_out, tx_ready, tx_busy});
        end
    endtask

    task automatic test_idle_activity;
        int lows, d0, e0;
        lows = 0; d0 = done_cnt; e0 = err_cnt;
        for (int i = 0; i < 3; i++) begin
            dev_clk = 1'b0;
            repeat (HALF) begin @(negedge clk); if (ps2_clk_out !== 1'b1 || ps2_dat_out !== 1'b1 || tx_ready !== 1'b1) lows++; end
            dev_clk = 1'b1;
            repeat (HALF) begin @(negedge clk); if (ps2_clk_out !== 1'b1 || ps2_dat_out !== 1'b1 || tx_ready !== 1'b1) lows++; end
        end
        total++;
        if (lows != 0 || done_cnt != d0 || err_cnt != e0) begin
            bad++; $display("FAIL idle_activity: bad cycles %0d pulses %0d want 0 0", lows, (done_cnt - d0) + (err_cnt - e0));
        end
    endtask

    task automatic test_send_ed;
        run_good_frame(8'hED, 10'h3ED);
    endtask

    task automatic test_send_f4;
        run_good_frame(8'hF4, 10'h2F4);
    endtask

    task automatic test_nack;
        int low, d0, e0;
        logic st;
        logic [9:0] bits;
        d0 = done_cnt; e0 = err_cnt;
        start_tx(8'hFF);
        dev_wait_release(low, st);
        repeat (HALF) @(negedge clk);
        dev_clocks(11, 1'b1, bits);
        total++;
        if (bits !== 10'h3FF) begin bad++; $display("FAIL nack_frame_bits: got %h want 3ff", bits); end
`ifdef PS2_TX_RETRY_EN
        total++;
        if (err_cnt != e0 || tx_busy !== 1'b1) begin bad++; $display("FAIL retry_silent: err %0d busy %b want 0 1", err_cnt - e0, tx_busy); end
        dev_wait_release(low, st);
        repeat (HALF) @(negedge clk);
        dev_clocks(11, 1'b1, bits);
        total++;
        if (bits !== 10'h3FF) begin bad++; $display("FAIL retry_frame_bits: got %h want 3ff", bits); end
`endif
        repeat (5) @(negedge clk);
        total++;
        if (err_cnt - e0 != 1 || done_cnt - d0 != 0) begin
            bad++; $display("FAIL nack_pulses: err %0d done %0d want 1 0", err_cnt - e0, done_cnt - d0);
        end
        total++;
        if ({ps2_clk_out, ps2_dat_out, tx_ready} !== 3'b111) begin
            bad++; $display("FAIL nack_release: got %b want 111", {ps2_clk_out, ps2_dat_out, tx_ready});
        end
    endtask

    task automatic test_start_timeout;
        int low, k, exp_k, e0;
        logic st;
        e0 = err_cnt;
        exp_k = START_CYC;
`ifdef PS2_TX_RETRY_EN
        exp_k = START_CYC + INH_TOTAL + START_CYC;
`endif
        start_tx(8'hED);
        dev_wait_release(low, st);
        k = 0;
        while (k < 40000) begin @(negedge clk); k++; if (tx_error === 1'b1) break; end
        total++;
        if (k < exp_k - 1 || k > exp_k + 1) begin bad++; $display("FAIL start_timeout: got %0d want %0d", k, exp_k); end
        repeat (3) @(negedge clk);
        total++;
        if ({ps2_clk_out, ps2_dat_out} !== 2'b11 || err_cnt - e0 != 1) begin
            bad++; $display("FAIL start_tmo_release: lines %b err %0d want 11 1", {ps2_clk_out, ps2_dat_out}, err_cnt - e0);
        end
    endtask

    task automatic test_bit_timeout;
        int low, k, lo, hi, lows, d0, e0;
        logic st;
        logic [9:0] bits;
        d0 = done_cnt; e0 = err_cnt;
        lo = BIT_CYC;
        hi = BIT_CYC + FLEN + 4;
`ifdef PS2_TX_RETRY_EN
        lo = lo + INH_TOTAL + START_CYC;
        hi = hi + INH_TOTAL + START_CYC;
`endif
        start_tx(8'hA5);
        dev_wait_release(low, st);
        repeat (HALF) @(negedge clk);
        dev_clocks(4, 1'b0, bits);
        total++;
        if (bits[3:0] !== 4'b0101) begin bad++; $display("FAIL stall_bits: got %b want 0101", bits[3:0]); end
        dev_clk = 1'b0;
        k = 0;
        while (k < 40000) begin
            @(negedge clk);
            k++;
            if (k == HALF) dev_clk = 1'b1;
            if (k == 500) begin
                total++;
                if ({tx_busy, tx_ready} !== 2'b10) begin bad++; $display("FAIL stall_busy: got %b want 10", {tx_busy, tx_ready}); end
                tx_data  = 8'h00;
                tx_valid = 1'b1;
            end
            if (k == 501) tx_valid = 1'b0;
            if (tx_error === 1'b1) break;
        end
        total++;
        if (k < lo || k > hi) begin bad++; $display("FAIL bit_timeout: got %0d want %0d..%0d", k, lo, hi); end
        lows = 0;
        repeat (50) begin @(negedge clk); if (ps2_clk_out !== 1'b1 || ps2_dat_out !== 1'b1) lows++; end
        total++;
        if (lows != 0 || tx_ready !== 1'b1) begin bad++; $display("FAIL ignored_valid: busy cycles %0d ready %b want 0 1", lows, tx_ready); end
        total++;
        if (err_cnt - e0 != 1 || done_cnt - d0 != 0) begin
            bad++; $display("FAIL stall_pulses: err %0d done %0d want 1 0", err_cnt - e0, done_cnt - d0);
        end
    endtask

    task automatic test_reset_mid_shift;
        int low, d0, e0;
        logic st;
        logic [9:0] bits;
        d0 = done_cnt; e0 = err_cnt;
        start_tx(8'h00);
        dev_wait_release(low, st);
        repeat (HALF) @(negedge clk);
        dev_clocks(3, 1'b0, bits);
        dev_clk = 1'b0;
        repeat (20) @(negedge clk);
        total++;
        if (ps2_dat_out !== 1'b0) begin bad++; $display("FAIL shift_data_low: got %b want 0", ps2_dat_out); end
        rst = 1'b1;
        #1;
        total++;
        if ({ps2_clk_out, ps2_dat_out, tx_busy} !== 3'b110) begin
            bad++; $display("FAIL async_reset_release: got %b want 110", {ps2_clk_out, ps2_dat_out, tx_busy});
        end
        dev_clk = 1'b1;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        total++;
        if (done_cnt != d0 || err_cnt != e0) begin
            bad++; $display("FAIL reset_no_pulse: done %0d err %0d want 0 0", done_cnt - d0, err_cnt - e0);
        end
        run_good_frame(8'hF4, 10'h2F4);
    endtask

    initial begin
        test_reset();
        test_idle_activity();
        test_send_ed();
        test_send_f4();
        test_nack();
        test_start_timeout();
        test_bit_timeout();
        test_reset_mid_shift();
        total++;
        if (both_cnt != 0) begin bad++; $display("FAIL done_and_error_together: got %0d want 0", both_cnt); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
